// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR run controller slice.
package fir_pkg;

  localparam int unsigned NB_COEFF_DEF = 8;
  localparam int unsigned N_COEFFS_DEF = 8;
  localparam int unsigned N_LANES      = 4;

  // Run state encoding, also visible on o_state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Ceiling log2; returns 0 for n <= 1
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (longint unsigned v = 1; v < longint'(n); v = v << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_run_ctrl_if.sv
// Coefficient configuration port: write handshake plus commit strobe.
interface fir_run_ctrl_if #(
  parameter int unsigned NB_COEFF = 8,
  parameter int unsigned NB_ADDR  = 3
);

  logic                i_cfg_valid;
  logic                o_cfg_ready;
  logic [NB_ADDR-1:0]  i_cfg_addr;
  logic [NB_COEFF-1:0] i_cfg_data;
  logic                i_cfg_commit;

  modport master (
    output i_cfg_valid,
    output i_cfg_addr,
    output i_cfg_data,
    output i_cfg_commit,
    input  o_cfg_ready
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_addr,
    input  i_cfg_data,
    input  i_cfg_commit,
    output o_cfg_ready
  );

endinterface

// File: rtl/fir_coeff_bank.sv
// Shadow + active coefficient register file with atomic shadow->active copy.
module fir_coeff_bank #(
  parameter int unsigned NB_COEFF = 8,
  parameter int unsigned N_COEFFS = 8,
  parameter int unsigned NB_ADDR  = 3
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [NB_ADDR-1:0]           wr_addr,
  input  logic [NB_COEFF-1:0]          wr_data,
  input  logic                         commit,
  output logic [N_COEFFS*NB_COEFF-1:0] coeffs
);

  logic [NB_COEFF-1:0]          shadow_q [N_COEFFS];
  logic [N_COEFFS*NB_COEFF-1:0] active_q;

  // Shadow writes and commit copy; the copy reads shadow before this edge's write.
  // Addresses with no matching tap simply never match and are dropped.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_COEFFS); k++) begin
        shadow_q[k] <= '0;
      end
      active_q <= '0;
    end else begin
      for (int k = 0; k < int'(N_COEFFS); k++) begin
        if (wr_en && (wr_addr == NB_ADDR'(k))) begin
          shadow_q[k] <= wr_data;
        end
        if (commit) begin
          active_q[k*NB_COEFF +: NB_COEFF] <= shadow_q[k];
        end
      end
    end
  end

  assign coeffs = active_q;

endmodule

// File: rtl/fir_run_ctrl.sv
// Run/config controller for the 4-lane FIR: coefficient banks, flush/warm-up/run/drain
// sequencing and lane-output valid tracking.
module fir_run_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned NB_COEFF = NB_COEFF_DEF,
  parameter int unsigned N_COEFFS = N_COEFFS_DEF,
  parameter int unsigned WARMUP   = 3,
  parameter int unsigned DRAIN    = 1,
  parameter int unsigned NB_CNT   = 16
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_stop,
  fir_run_ctrl_if.slave                cfg,
  output logic [N_COEFFS*NB_COEFF-1:0] o_coeffs,
  output logic                         o_fir_enable,
  output logic                         o_fir_rst_n,
  output logic                         o_data_valid,
  output logic                         o_commit_pend,
  output logic [1:0]                   o_state,
  output logic [NB_CNT-1:0]            o_block_cnt
);

  localparam int unsigned NB_ADDR  = (clog2(N_COEFFS) > 0) ? clog2(N_COEFFS) : 1;
  localparam int unsigned NB_WARM  = (clog2(WARMUP + 1) > 0) ? clog2(WARMUP + 1) : 1;
  localparam int unsigned NB_DRAIN = (clog2(DRAIN + 1) > 0) ? clog2(DRAIN + 1) : 1;

  state_e               state_q, state_d;
  logic [NB_WARM-1:0]   warm_q, warm_d, warm_dec;
  logic [NB_DRAIN-1:0]  drain_q, drain_d;
  logic                 pend_q, pend_d;
  logic                 apply;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 enable_q, rst_n_q;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;

  // Next-state, counters and commit decision
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    warm_dec = (warm_q != '0) ? warm_q - 1'b1 : '0;
    warm_d   = warm_q;
    cnt_d    = cnt_q + NB_CNT'(valid_q);
    // Stop wins over a pending commit in RUN; FLUSH/DRAIN hold the commit back
    apply    = pend_q && ((state_q == ST_IDLE) || ((state_q == ST_RUN) && !i_stop));

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
        warm_d  = NB_WARM'(WARMUP);
      end
      ST_RUN: begin
        warm_d = warm_dec;
        if (i_stop) begin
          state_d = ST_DRAIN;
          drain_d = NB_DRAIN'(DRAIN);
        end else if (apply) begin
          // Delay line keeps mixed-coefficient samples; mask them by re-warming
          warm_d = NB_WARM'(WARMUP);
        end
      end
      ST_DRAIN: begin
        warm_d = warm_dec;
        if (drain_q <= NB_DRAIN'(1)) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pend_d  = apply ? 1'b0 : (pend_q || cfg.i_cfg_commit);
    // Block writes in the cycle a commit is expected to be applied
    ready_d = !(pend_d && ((state_d == ST_IDLE) || (state_d == ST_RUN)));
    valid_d = ((state_d == ST_RUN) || (state_d == ST_DRAIN)) && (warm_d == '0);
  end

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      warm_q   <= '0;
      drain_q  <= '0;
      pend_q   <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      enable_q <= 1'b0;
      rst_n_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      drain_q  <= drain_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      enable_q <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      rst_n_q  <= (state_d != ST_FLUSH);
      cnt_q    <= cnt_d;
    end
  end

  fir_coeff_bank #(
    .NB_COEFF (NB_COEFF),
    .N_COEFFS (N_COEFFS),
    .NB_ADDR  (NB_ADDR)
  ) u_bank (
    .clock   (clock),
    .rst_n   (i_reset),
    .wr_en   (cfg.i_cfg_valid && ready_q),
    .wr_addr (cfg.i_cfg_addr),
    .wr_data (cfg.i_cfg_data),
    .commit  (apply),
    .coeffs  (o_coeffs)
  );

  assign cfg.o_cfg_ready = ready_q;
  assign o_fir_enable    = enable_q;
  assign o_fir_rst_n     = rst_n_q;
  assign o_data_valid    = valid_q;
  assign o_commit_pend   = pend_q;
  assign o_state         = state_q;
  assign o_block_cnt     = cnt_q;

endmodule

// File: tb/tb_fir_run_ctrl.sv
// Directed bench for fir_run_ctrl (4-bit block counter to exercise wrap).
module tb_fir_run_ctrl;
  import fir_pkg::*;

  logic        clock = 1'b0;
  logic        i_reset, i_start, i_stop;
  logic [63:0] o_coeffs;
  logic        o_fir_enable, o_fir_rst_n, o_data_valid, o_commit_pend;
  logic [1:0]  o_state;
  logic [3:0]  o_block_cnt;
  logic [63:0] exp_coeffs;

  int n_checks = 0;
  int n_fails  = 0;

  fir_run_ctrl_if #(.NB_COEFF(8), .NB_ADDR(3)) cfg ();

  fir_run_ctrl #(
    .NB_COEFF (8),
    .N_COEFFS (8),
    .WARMUP   (3),
    .DRAIN    (1),
    .NB_CNT   (4)
  ) dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .cfg           (cfg),
    .o_coeffs      (o_coeffs),
    .o_fir_enable  (o_fir_enable),
    .o_fir_rst_n   (o_fir_rst_n),
    .o_data_valid  (o_data_valid),
    .o_commit_pend (o_commit_pend),
    .o_state       (o_state),
    .o_block_cnt   (o_block_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [1:0] st, input logic en,
                         input logic rn, input logic vld, input logic pend, input logic rdy,
                         input logic [3:0] cnt);
    chk({tag, ".state"}, 64'(o_state), 64'(st));
    chk({tag, ".enable"}, 64'(o_fir_enable), 64'(en));
    chk({tag, ".rst_n"}, 64'(o_fir_rst_n), 64'(rn));
    chk({tag, ".valid"}, 64'(o_data_valid), 64'(vld));
    chk({tag, ".pend"}, 64'(o_commit_pend), 64'(pend));
    chk({tag, ".ready"}, 64'(cfg.o_cfg_ready), 64'(rdy));
    chk({tag, ".cnt"}, 64'(o_block_cnt), 64'(cnt));
  endtask

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    cfg.i_cfg_valid = 1'b0; cfg.i_cfg_addr = '0; cfg.i_cfg_data = '0; cfg.i_cfg_commit = 1'b0;

    // Reset state
    tick();
    chk_ctl("rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("rst.coeffs", o_coeffs, 64'd0);
    i_reset = 1'b1;
    tick();
    chk_ctl("idle", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);

    // Load taps 0..7 = 1..8, then commit in IDLE
    for (int k = 0; k < 8; k++) begin
      cfg.i_cfg_valid = 1'b1; cfg.i_cfg_addr = 3'(k); cfg.i_cfg_data = 8'(k + 1);
      exp_coeffs[k*8 +: 8] = 8'(k + 1);
      tick();
    end
    cfg.i_cfg_valid = 1'b0;
    chk("shadow.not_active", o_coeffs, 64'd0);
    cfg.i_cfg_commit = 1'b1;
    tick();
    cfg.i_cfg_commit = 1'b0;
    chk_ctl("commit.pend", 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("commit.pend.coeffs", o_coeffs, 64'd0);
    tick();
    chk_ctl("commit.done", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("commit.tap3", 64'(o_coeffs[24 +: 8]), 64'd4);
    chk("commit.coeffs", o_coeffs, exp_coeffs);

    // Stop in IDLE is ignored
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("idle.stop_ignored", 64'(o_state), 64'd0);

    // Start: FLUSH, RUN, warm-up of 3 cycles
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk_ctl("flush", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    chk_ctl("run.r0", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    chk("run.r1.valid", 64'(o_data_valid), 64'd0);
    tick();
    chk("run.r2.valid", 64'(o_data_valid), 64'd0);
    tick();
    chk_ctl("run.r3", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    repeat (5) tick();
    chk_ctl("run.r8", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);

    // Write tap0 = -3 with a same-cycle commit in RUN
    cfg.i_cfg_valid = 1'b1; cfg.i_cfg_addr = 3'd0; cfg.i_cfg_data = 8'hFD;
    cfg.i_cfg_commit = 1'b1;
    tick();
    cfg.i_cfg_valid = 1'b0; cfg.i_cfg_commit = 1'b0;
    chk_ctl("runcommit.pend", 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd6);
    tick();
    exp_coeffs[7:0] = 8'hFD;
    chk_ctl("runcommit.w0", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
    chk("runcommit.coeffs", o_coeffs, exp_coeffs);
    tick();
    chk_ctl("runcommit.w1", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
    tick();
    chk_ctl("runcommit.w2", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
    tick();
    chk_ctl("runcommit.w3", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7);

    // Stage tap7 = 0x11 in shadow, then stop + commit together
    cfg.i_cfg_valid = 1'b1; cfg.i_cfg_addr = 3'd7; cfg.i_cfg_data = 8'h11;
    tick();
    cfg.i_cfg_valid = 1'b0;
    chk("stage.coeffs", o_coeffs, exp_coeffs);
    i_stop = 1'b1; cfg.i_cfg_commit = 1'b1;
    tick();
    i_stop = 1'b0; cfg.i_cfg_commit = 1'b0;
    chk_ctl("drain", 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
    chk("drain.coeffs", o_coeffs, exp_coeffs);
    tick();
    chk_ctl("drain.idle", 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10);
    chk("drain.idle.coeffs", o_coeffs, exp_coeffs);
    tick();
    exp_coeffs[63:56] = 8'h11;
    chk_ctl("drain.applied", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd10);
    chk("drain.applied.coeffs", o_coeffs, exp_coeffs);

    // Reset mid-RUN aborts immediately and clears both banks
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("restart.cnt_cleared", 64'(o_block_cnt), 64'd0);
    tick();
    tick();
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    chk_ctl("midrst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("midrst.coeffs", o_coeffs, 64'd0);
    tick();
    cfg.i_cfg_commit = 1'b1;
    tick();
    cfg.i_cfg_commit = 1'b0;
    tick();
    chk("midrst.shadow_cleared", o_coeffs, 64'd0);

    // Counter wrap over 20 valid cycles; start in RUN ignored
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    chk("wrap.r0.state", 64'(o_state), 64'd2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("wrap.start_ignored", 64'(o_state), 64'd2);
    tick();
    tick();
    chk_ctl("wrap.r3", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    repeat (15) tick();
    chk("wrap.r18.cnt", 64'(o_block_cnt), 64'd15);
    tick();
    chk("wrap.r19.cnt", 64'(o_block_cnt), 64'd0);
    repeat (4) tick();
    chk_ctl("wrap.r23", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
